// File: rtl/weight_arb_pkg.sv
// Shared types and default widths for the weight-memory read arbiter.
package weight_arb_pkg;

    localparam int unsigned WT_NUM_REQ = 4;
    localparam int unsigned WT_ADDR_W  = 19;
    localparam int unsigned WT_DATA_W  = 128;
    localparam int unsigned WT_CNT_W   = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // Index width for a requester number, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above ptr, wrapping.
module rr_pick
    import weight_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = WT_NUM_REQ,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner_c = '0;
        idx_c    = '0;
        any_c    = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!any_c && req[cand]) begin
                winner_c[cand] = 1'b1;
                idx_c          = cand;
                any_c          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/weight_rd_arbiter.sv
// Shares one weight-memory read port between NUM_REQ schedulers, one burst
// at a time, routing in-order returns back to the owner of the burst.
module weight_rd_arbiter
    import weight_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = WT_NUM_REQ,
    parameter int unsigned ADDR_W  = WT_ADDR_W,
    parameter int unsigned DATA_W  = WT_DATA_W,
    parameter int unsigned CNT_W   = WT_CNT_W
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_base,
    input  logic [NUM_REQ*CNT_W-1:0]  req_count,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        wvalid,
    output logic [DATA_W-1:0]         wdata,
    output logic [NUM_REQ-1:0]        wdone,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic [DATA_W-1:0]         mem_rd_data,
    input  logic                      mem_rd_valid,
    output logic                      busy,
    output logic                      err_stray
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    issued_q, issued_d;
    logic [CNT_W-1:0]    rcvd_q, rcvd_d;

    logic [NUM_REQ-1:0]  grant_d, wvalid_d, wdone_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_rd_addr_d;
    logic                busy_d, err_stray_d;

    logic [NUM_REQ-1:0]  pick_winner;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [ADDR_W-1:0]   sel_base;
    logic [CNT_W-1:0]    sel_count;
    logic [NUM_REQ-1:0]  owner_oh;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .winner_c (pick_winner),
        .idx_c    (pick_idx),
        .any_c    (pick_any)
    );

    assign owner_oh = NUM_REQ'(1) << owner_q;

    // Burst parameters of the current pick, muxed with the one-hot winner.
    always_comb begin
        sel_base  = '0;
        sel_count = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_winner[i]) begin
                sel_base  = req_base[i*ADDR_W +: ADDR_W];
                sel_count = req_count[i*CNT_W +: CNT_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        base_d        = base_q;
        count_d       = count_q;
        issued_d      = issued_q;
        rcvd_d        = rcvd_q;
        grant_d       = '0;
        wvalid_d      = '0;
        wdone_d       = '0;
        wdata_d       = wdata;
        mem_rd_en_d   = 1'b0;
        mem_rd_addr_d = mem_rd_addr;
        err_stray_d   = err_stray;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d  = pick_winner;
                    owner_d  = pick_idx;
                    ptr_d    = pick_idx;
                    base_d   = sel_base;
                    count_d  = sel_count;
                    issued_d = '0;
                    rcvd_d   = '0;
                    state_d  = (sel_count == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                mem_rd_en_d   = 1'b1;
                mem_rd_addr_d = base_q + ADDR_W'(issued_q);
                issued_d      = issued_q + CNT_W'(1);
                if (issued_q == count_q - CNT_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Zero-length burst completes the cycle after its grant.
                if (count_q == '0) begin
                    wdone_d = owner_oh;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Returns belong to the open burst until all of its beats are in.
        if (mem_rd_valid) begin
            if (state_q != IDLE && rcvd_q < count_q) begin
                wvalid_d = owner_oh;
                wdata_d  = mem_rd_data;
                rcvd_d   = rcvd_q + CNT_W'(1);
                if (rcvd_q == count_q - CNT_W'(1)) begin
                    wdone_d = owner_oh;
                    state_d = IDLE;
                end
            end else begin
                err_stray_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            owner_q     <= '0;
            base_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            rcvd_q      <= '0;
            grant       <= '0;
            wvalid      <= '0;
            wdata       <= '0;
            wdone       <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            busy        <= 1'b0;
            err_stray   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            base_q      <= base_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            rcvd_q      <= rcvd_d;
            grant       <= grant_d;
            wvalid      <= wvalid_d;
            wdata       <= wdata_d;
            wdone       <= wdone_d;
            mem_rd_en   <= mem_rd_en_d;
            mem_rd_addr <= mem_rd_addr_d;
            busy        <= busy_d;
            err_stray   <= err_stray_d;
        end
    end

endmodule

// File: tb/tb_weight_rd_arbiter.sv
// Bench for weight_rd_arbiter: directed burst table, corner sequences and
// random traffic against a schedule-based reference model and memory model.
module tb_weight_rd_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned CNT_W   = 11;

    logic                      CLK = 1'b0;
    logic                      RESET = 1'b1;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_base = '0;
    logic [NUM_REQ*CNT_W-1:0]  req_count = '0;
    logic [NUM_REQ-1:0]        grant, wvalid, wdone;
    logic [DATA_W-1:0]         wdata;
    logic                      mem_rd_en;
    logic [ADDR_W-1:0]         mem_rd_addr;
    logic [DATA_W-1:0]         mem_rd_data = '0;
    logic                      mem_rd_valid = 1'b0;
    logic                      busy, err_stray;

    weight_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RESET(RESET), .req(req), .req_base(req_base), .req_count(req_count),
        .grant(grant), .wvalid(wvalid), .wdata(wdata), .wdone(wdone),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_rd_valid(mem_rd_valid), .busy(busy), .err_stray(err_stray)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Memory model: in-order returns, latency >= 1, one return per cycle.
    typedef struct { logic [ADDR_W-1:0] addr; int due; } rd_t;
    rd_t mq[$];
    int  last_due = 0;
    int  mem_lat = 2;
    bit  mem_rand = 0;
    bit  stray_req = 0;

    // Reference model: expected read schedule and burst bookkeeping.
    typedef struct { int cyc; logic [ADDR_W-1:0] addr; } sched_t;
    sched_t rs[$];
    bit m_open = 0, m_rst = 0;
    int m_owner = 0, m_last = NUM_REQ - 1, m_cnt = 0, m_rcv = 0, m_zero_cyc = 0;
    logic [NUM_REQ-1:0] e_grant, e_wvalid, e_wdone;
    logic               e_en, e_busy, e_err;
    logic [ADDR_W-1:0]  e_addr;
    logic [DATA_W-1:0]  e_wdata;

    int obs_reads, obs_beats, obs_done;
    logic [NUM_REQ-1:0] obs_grant;
    logic [ADDR_W-1:0]  obs_addr[$];

    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic [ADDR_W-1:0]  base;
        logic [CNT_W-1:0]   cnt;
        int                 lat;
        logic [NUM_REQ-1:0] exp_grant;
        int                 exp_beats;
        logic [ADDR_W-1:0]  exp_last;
    } vec_t;
    vec_t tbl[15];

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic logic [DATA_W-1:0] mdata(input logic [ADDR_W-1:0] a);
        logic [31:0] x;
        x = 32'(a);
        return {x ^ 32'hDEAD0000, ~x, x * 32'd3, x + 32'h1234};
    endfunction

    function automatic int pick(input logic [NUM_REQ-1:0] r, input int last);
        int j;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            j = (last + k) % int'(NUM_REQ);
            if (r[j]) return j;
        end
        return -1;
    endfunction

    // Expected outputs for cycle cyc from the inputs held during cycle cyc-1.
    task automatic model_step();
        bit was_open;
        int w;
        logic [CNT_W-1:0]  n;
        logic [ADDR_W-1:0] b;
        e_grant = '0; e_wvalid = '0; e_wdone = '0; e_en = 1'b0; m_rst = 0;
        if (RESET) begin
            m_rst = 1; m_open = 0; m_last = NUM_REQ - 1; e_err = 1'b0; e_busy = 1'b0;
            rs.delete();
            return;
        end
        was_open = m_open;
        if (mem_rd_valid) begin
            if (was_open && m_rcv < m_cnt) begin
                e_wvalid = NUM_REQ'(1) << m_owner;
                e_wdata  = mem_rd_data;
                m_rcv++;
                if (m_rcv == m_cnt) begin
                    e_wdone = NUM_REQ'(1) << m_owner;
                    m_open  = 0;
                end
            end else begin
                e_err = 1'b1;
            end
        end
        if (!was_open) begin
            w = pick(req, m_last);
            if (w >= 0) begin
                n = req_count[w*CNT_W +: CNT_W];
                b = req_base[w*ADDR_W +: ADDR_W];
                e_grant = NUM_REQ'(1) << w;
                m_last = w; m_owner = w; m_open = 1; m_cnt = int'(n); m_rcv = 0;
                m_zero_cyc = cyc + 1;
                for (int i = 0; i < m_cnt; i++)
                    rs.push_back('{cyc: cyc + 1 + i, addr: ADDR_W'(b + ADDR_W'(i))});
            end
        end else begin
            if (rs.size() > 0 && rs[0].cyc == cyc) begin
                e_en = 1'b1;
                e_addr = rs[0].addr;
                void'(rs.pop_front());
            end
            if (m_cnt == 0 && cyc == m_zero_cyc) begin
                e_wdone = NUM_REQ'(1) << m_owner;
                m_open = 0;
            end
        end
        e_busy = m_open;
    endtask

    task automatic tick();
        int due;
        @(negedge CLK);
        cyc++;
        model_step();
        chk("grant", 128'(grant), 128'(e_grant));
        chk("wvalid", 128'(wvalid), 128'(e_wvalid));
        chk("wdone", 128'(wdone), 128'(e_wdone));
        chk("mem_rd_en", 128'(mem_rd_en), 128'(e_en));
        chk("busy", 128'(busy), 128'(e_busy));
        chk("err_stray", 128'(err_stray), 128'(e_err));
        if (e_en) chk("mem_rd_addr", 128'(mem_rd_addr), 128'(e_addr));
        if (e_wvalid != '0) chk("wdata", 128'(wdata), 128'(e_wdata));
        if (m_rst) begin
            chk("rst rd_addr", 128'(mem_rd_addr), 128'(0));
            chk("rst wdata", 128'(wdata), 128'(0));
        end
        if (grant != '0) obs_grant = grant;
        if (mem_rd_en) begin obs_reads++; obs_addr.push_back(mem_rd_addr); end
        if (wvalid != '0) obs_beats++;
        if (wdone != '0) obs_done++;
        if (mem_rd_en) begin
            due = cyc + (mem_rand ? int'($urandom_range(1, 4)) : mem_lat);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: mem_rd_addr, due: due});
        end
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mdata(mq[0].addr);
            void'(mq.pop_front());
        end else if (stray_req) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = {4{$urandom()}};
            stray_req    = 0;
        end
    endtask

    task automatic set_all(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_base[i*ADDR_W +: ADDR_W] = b;
            req_count[i*CNT_W +: CNT_W]  = n;
        end
    endtask

    task automatic clear_obs();
        obs_reads = 0; obs_beats = 0; obs_done = 0; obs_grant = '0;
        obs_addr.delete();
    endtask

    task automatic wait_grant(input string nm);
        int bud = 0;
        while (obs_grant == '0 && bud < 20) begin tick(); bud++; end
        if (obs_grant == '0) chk({nm, " grant timeout"}, 128'(0), 128'(1));
    endtask

    task automatic wait_done(input string nm);
        int bud = 0;
        while (obs_done == 0 && bud < 100) begin tick(); bud++; end
        chk({nm, " done"}, 128'(obs_done), 128'(1));
    endtask

    task automatic run_row(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("row%0d", idx);
        clear_obs();
        mem_lat = v.lat;
        set_all(v.base, v.cnt);
        req = v.req;
        wait_grant(nm);
        req = '0;
        chk({nm, " grant"}, 128'(obs_grant), 128'(v.exp_grant));
        wait_done(nm);
        chk({nm, " beats"}, 128'(obs_beats), 128'(v.exp_beats));
        chk({nm, " reads"}, 128'(obs_reads), 128'(v.exp_beats));
        if (obs_addr.size() > 0) begin
            chk({nm, " first addr"}, 128'(obs_addr[0]), 128'(v.base));
            chk({nm, " last addr"}, 128'(obs_addr[obs_addr.size()-1]), 128'(v.exp_last));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc %0d got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int bud;
        for (int i = 0; i < 8; i++)
            tbl[i] = '{4'b1111, 19'h00200, 11'd2, 2, 4'(1 << (i % 4)), 2, 19'h00201};
        tbl[8]  = '{4'b0001, 19'h00100, 11'd4, 3, 4'b0001, 4, 19'h00103};
        tbl[9]  = '{4'b0100, 19'h00000, 11'd0, 1, 4'b0100, 0, 19'h00000};
        tbl[10] = '{4'b1000, 19'h7FFFE, 11'd4, 1, 4'b1000, 4, 19'h00001};
        tbl[11] = '{4'b0110, 19'h00040, 11'd3, 4, 4'b0010, 3, 19'h00042};
        tbl[12] = '{4'b0110, 19'h00040, 11'd3, 4, 4'b0100, 3, 19'h00042};
        tbl[13] = '{4'b1001, 19'h7FFFF, 11'd1, 2, 4'b1000, 1, 19'h7FFFF};
        tbl[14] = '{4'b1001, 19'h7FFFF, 11'd1, 2, 4'b0001, 1, 19'h7FFFF};

        repeat (3) tick();
        RESET = 1'b0;
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset grant", 128'(grant), 128'(0));
        chk("reset err", 128'(err_stray), 128'(0));
        repeat (2) tick();

        for (int r = 0; r < 15; r++) run_row(tbl[r], r);

        // Stray return while idle.
        tick();
        chk("err before stray", 128'(err_stray), 128'(0));
        clear_obs();
        stray_req = 1;
        repeat (5) tick();
        chk("stray no beat", 128'(obs_beats), 128'(0));
        chk("stray sticky", 128'(err_stray), 128'(1));

        // Reset after two of four reads issued.
        clear_obs();
        mem_lat = 3;
        set_all(19'h00300, 11'd4);
        req = 4'b0001;
        bud = 0;
        while (obs_reads < 2 && bud < 30) begin
            tick();
            if (obs_grant != '0) req = '0;
            bud++;
        end
        chk("mid reads", 128'(obs_reads), 128'(2));
        RESET = 1'b1;
        #1;
        chk("mid rst grant", 128'(grant), 128'(0));
        chk("mid rst wvalid", 128'(wvalid), 128'(0));
        chk("mid rst wdone", 128'(wdone), 128'(0));
        chk("mid rst en", 128'(mem_rd_en), 128'(0));
        chk("mid rst addr", 128'(mem_rd_addr), 128'(0));
        chk("mid rst wdata", 128'(wdata), 128'(0));
        chk("mid rst busy", 128'(busy), 128'(0));
        chk("mid rst err", 128'(err_stray), 128'(0));
        repeat (2) tick();
        RESET = 1'b0;
        clear_obs();
        repeat (8) tick();
        chk("no wdone after rst", 128'(obs_done), 128'(0));
        chk("late return stray", 128'(err_stray), 128'(1));
        set_all(19'h00010, 11'd1);
        req = 4'b1111;
        wait_grant("post rst");
        req = '0;
        chk("post rst grant", 128'(obs_grant), 128'(4'b0001));
        wait_done("post rst");

        // Random traffic against the model.
        mem_rand = 1;
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (req[i] && grant[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 3) == 0)
                        req_base[i*ADDR_W +: ADDR_W] = ADDR_W'(19'h7FFFC + ADDR_W'($urandom_range(0, 3)));
                    else
                        req_base[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom());
                    req_count[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 5));
                    req[i] = 1'b1;
                end
            end
        end
        req = '0;
        bud = 0;
        while ((m_open || mq.size() > 0) && bud < 200) begin tick(); bud++; end
        chk("drain idle", 128'(busy), 128'(0));
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
